// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encodings, port indices and default widths for dmem_arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_LOCK_MAX = 4;

    // Read-wait counter holds RD_LAT-1, and RD_LAT never exceeds 4
    localparam int WCNT_W = 2;

    function automatic logic [1:0] port_onehot(input logic p);
        logic [1:0] oh;
        oh    = '0;
        oh[p] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - combinational two-way round-robin picker with lock override
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       hold_i,
    input  logic       hold_port_i,
    output logic       sel_o,
    output logic       any_o
);

    always_comb begin
        any_o = |req_i;
        sel_o = 1'(PORT_CPU);
        case (req_i)
            2'b01:   sel_o = 1'(PORT_CPU);
            2'b10:   sel_o = 1'(PORT_DBG);
            // A held lock keeps the current owner; otherwise the port not served last wins
            2'b11:   sel_o = hold_i ? hold_port_i : ~last_i;
            default: sel_o = 1'(PORT_CPU);
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data-memory arbiter; bus lock enabled by DMEM_ARB_LOCK_EN
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        lock,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_q, last_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                pick_sel, pick_any;
    logic                hold, hold_port;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_wdata;

    rr_pick2 u_pick (
        .req_i       (req),
        .last_i      (last_q),
        .hold_i      (hold),
        .hold_port_i (hold_port),
        .sel_o       (pick_sel),
        .any_o       (pick_any)
    );

    assign pick_addr  = pick_sel ? addr1  : addr0;
    assign pick_wdata = pick_sel ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = mem_we_q ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (wcnt_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory-side fields double as the captured request: they are loaded on
    // the arbitration edge and held until the next grant
    always_comb begin
        sel_d       = sel_q;
        wcnt_d      = wcnt_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d       = pick_sel;
                    gnt_d       = port_onehot(pick_sel);
                    mem_en_d    = 1'b1;
                    mem_we_d    = we[pick_sel];
                    mem_addr_d  = pick_addr;
                    mem_wdata_d = pick_wdata;
                end
            end
            ST_ISSUE: wcnt_d = WCNT_W'(RD_LAT - 1);
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = port_onehot(sel_q);
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q       <= 1'b0;
            last_q      <= 1'(PORT_DBG);
            wcnt_q      <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            sel_q       <= sel_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    logic [LCNT_W-1:0] lcnt_q, lcnt_d, lcnt_nxt;
    logic              lport_q, lport_d;

    // lcnt counts consecutive locked grants to lport; at the cap the pointer
    // finally rotates so the other port gets one turn
    always_comb begin
        last_d   = last_q;
        lcnt_d   = lcnt_q;
        lport_d  = lport_q;
        lcnt_nxt = ((lcnt_q != '0) && (lport_q == sel_q)) ? lcnt_q + 1'b1 : LCNT_W'(1);
        if (state_q == ST_ISSUE) begin
            if (lock[sel_q] && (lcnt_nxt < LCNT_W'(LOCK_MAX))) begin
                lcnt_d  = lcnt_nxt;
                lport_d = sel_q;
            end else begin
                lcnt_d = '0;
                last_d = sel_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lcnt_q  <= '0;
            lport_q <= 1'b0;
        end else begin
            lcnt_q  <= lcnt_d;
            lport_q <= lport_d;
        end
    end

    assign hold      = (lcnt_q != '0);
    assign hold_port = lport_q;
`else
    logic unused_lock;

    always_comb begin
        last_d = (state_q == ST_ISSUE) ? sel_q : last_q;
    end

    assign hold        = 1'b0;
    assign hold_port   = 1'b0;
    assign unused_lock = ^{lock, LOCK_MAX > 0};
`endif

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a cycle-timeline model
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int LMAX  = 4;
    localparam int NCYC  = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    req, we, lock;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    gnt, rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    logic [1:0]    req_b, we_b;
    logic [AW-1:0] addr_b1;
    logic [DW-1:0] wdata_b1;
    logic [1:0]    gnt_b, rvalid_b;
    logic [DW-1:0] rdata_b, mem_wdata_b, mem_rdata_b;
    logic          mem_en_b, mem_we_b;
    logic [AW-1:0] mem_addr_b;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock(lock),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .LOCK_MAX(LMAX)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b),
        .addr0(8'h00), .addr1(addr_b1), .wdata0(8'h00), .wdata1(wdata_b1), .lock(2'b00),
        .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 5 + 1);
    endfunction

    // Memory environments: read data appears only in the cycle it is due, junk otherwise
    logic [DW-1:0] env_mem [0:255];
    logic [3:0]    pv, pvb;
    logic [AW-1:0] pa [0:3];
    logic [AW-1:0] pab [0:3];
    logic [DW-1:0] junk;

    always @(posedge clk) begin
        junk <= DW'($urandom);
        if (!reset) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
            pv  <= '0;
            pvb <= '0;
        end else begin
            if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;
            pv  <= {pv[2:0], mem_en & ~mem_we};
            pvb <= {pvb[2:0], mem_en_b & ~mem_we_b};
        end
        pa[0]  <= mem_addr;
        pab[0] <= mem_addr_b;
        for (int k = 1; k < 4; k++) begin
            pa[k]  <= pa[k-1];
            pab[k] <= pab[k-1];
        end
    end

    assign mem_rdata   = pv[LAT_A-1]  ? env_mem[pa[LAT_A-1]] : junk;
    assign mem_rdata_b = pvb[LAT_B-1] ? pab[LAT_B-1] + 8'd38 : junk;

    // Reference timeline: each accepted request books its grant cycle and,
    // for reads, its rvalid cycle; the bus is then busy until the next sample point
    int            cyc = 0;
    int            busy_until = 0;
    int            issue_cyc = -10;
    int            m_lcnt = 0;
    logic          m_sel = 1'b0, m_last = 1'b1, m_lport = 1'b0;
    logic [DW-1:0] m_mem [0:255];
    logic [1:0]    e_gnt [NCYC] = '{default: '0};
    logic [1:0]    e_rv  [NCYC] = '{default: '0};
    logic          e_en  [NCYC] = '{default: 1'b0};
    logic          e_we  [NCYC] = '{default: 1'b0};
    logic          e_aw  [NCYC] = '{default: 1'b0};
    logic          e_rd  [NCYC] = '{default: 1'b0};
    logic          e_rst [NCYC] = '{default: 1'b0};
    logic [AW-1:0] e_addr[NCYC] = '{default: '0};
    logic [DW-1:0] e_wd  [NCYC] = '{default: '0};
    logic [DW-1:0] e_rdv [NCYC] = '{default: '0};

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            for (int i = cyc; i < cyc + 8 && i < NCYC; i++) begin
                e_gnt[i] = '0; e_rv[i] = '0; e_en[i] = 1'b0;
                e_we[i] = 1'b0; e_aw[i] = 1'b0; e_rd[i] = 1'b0;
            end
            if (cyc < NCYC) e_rst[cyc] = 1'b1;
            for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
            m_last = 1'b1; m_lcnt = 0; m_lport = 1'b0;
            busy_until = cyc + 1; issue_cyc = -10;
        end else begin
            if (issue_cyc == cyc - 1) begin
`ifdef DMEM_ARB_LOCK_EN
                if (lock[m_sel]) begin
                    int streak;
                    streak = (m_lcnt > 0 && m_lport == m_sel) ? m_lcnt + 1 : 1;
                    if (streak >= LMAX) begin
                        m_lcnt = 0; m_last = m_sel;
                    end else begin
                        m_lcnt = streak; m_lport = m_sel;
                    end
                end else begin
                    m_lcnt = 0; m_last = m_sel;
                end
`else
                m_last = m_sel;
`endif
            end
            if (cyc >= busy_until && req != 2'b00 && cyc + LAT_A + 1 < NCYC) begin
                if (req == 2'b01)      m_sel = 1'b0;
                else if (req == 2'b10) m_sel = 1'b1;
                else                   m_sel = (m_lcnt > 0) ? m_lport : ~m_last;
                e_gnt[cyc]  = m_sel ? 2'b10 : 2'b01;
                e_en[cyc]   = 1'b1;
                e_we[cyc]   = we[m_sel];
                e_aw[cyc]   = 1'b1;
                e_addr[cyc] = m_sel ? addr1 : addr0;
                e_wd[cyc]   = m_sel ? wdata1 : wdata0;
                if (we[m_sel]) begin
                    m_mem[e_addr[cyc]] = e_wd[cyc];
                    busy_until = cyc + 2;
                end else begin
                    e_rv[cyc + LAT_A + 1]  = e_gnt[cyc];
                    e_rd[cyc + LAT_A + 1]  = 1'b1;
                    e_rdv[cyc + LAT_A + 1] = m_mem[e_addr[cyc]];
                    busy_until = cyc + LAT_A + 2;
                end
                issue_cyc = cyc;
            end
        end
    end

    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wd = '0, c_rd = '0;

    always @(negedge clk) begin
        if (cyc > 0 && cyc < NCYC) begin
            if (e_rst[cyc]) begin c_addr = '0; c_wd = '0; c_rd = '0; end
            if (e_aw[cyc])  begin c_addr = e_addr[cyc]; c_wd = e_wd[cyc]; end
            if (e_rd[cyc])  c_rd = e_rdv[cyc];
            check_eq("m_gnt",       gnt,       e_gnt[cyc]);
            check_eq("m_rvalid",    rvalid,    e_rv[cyc]);
            check_eq("m_mem_en",    mem_en,    e_en[cyc]);
            check_eq("m_mem_we",    mem_we,    e_we[cyc]);
            check_eq("m_mem_addr",  mem_addr,  c_addr);
            check_eq("m_mem_wdata", mem_wdata, c_wd);
            check_eq("m_rdata",     rdata,     c_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
    endtask

    // Requesters hold until granted, sometimes withdraw, sometimes stay idle
    task automatic rand_cycle();
        for (int p = 0; p < 2; p++) begin
            if (gnt[p] || !req[p]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req[p] = 1'b1;
                    we[p]  = 1'($urandom_range(0, 1));
                    set_port(p, AW'($urandom_range(0, 15)), DW'($urandom));
                end else begin
                    req[p] = 1'b0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req[p] = 1'b0;
            end
        end
        lock = 2'($urandom);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seq [8];
        int  ngr, n1, t0;
        bit  ok;

        reset = 1'b0; req = 2'b11; we = 2'b00; lock = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        req_b = 2'b00; we_b = 2'b00; addr_b1 = '0; wdata_b1 = '0;

        step(); step();
        check_eq("rst_gnt",    gnt,    2'b00);
        check_eq("rst_rvalid", rvalid, 2'b00);
        check_eq("rst_mem_en", mem_en, 1'b0);
        reset = 1'b1;
        step();
        check_eq("first_gnt_port0", gnt, 2'b01);
        req = 2'b00;
        repeat (6) step();

        req = 2'b01; we = 2'b01; addr0 = 8'h04; wdata0 = 8'd42;
        step();
        check_eq("wr_gnt",    gnt,       2'b01);
        check_eq("wr_en",     mem_en,    1'b1);
        check_eq("wr_we",     mem_we,    1'b1);
        check_eq("wr_addr",   mem_addr,  8'h04);
        check_eq("wr_wdata",  mem_wdata, 8'd42);
        check_eq("wr_rvalid", rvalid,    2'b00);
        req = 2'b00;
        repeat (3) step();

        req = 2'b10; we = 2'b00; addr1 = 8'h04;
        step();
        check_eq("rd_gnt", gnt, 2'b10);
        req = 2'b00;
        step();
        check_eq("rd_rvalid_t1", rvalid, 2'b00);
        step();
        check_eq("rd_rvalid_t2", rvalid, 2'b10);
        check_eq("rd_rdata",     rdata,  8'd42);
        step();
        check_eq("rd_rvalid_off", rvalid, 2'b00);
        check_eq("rd_rdata_hold", rdata,  8'd42);

        req_b = 2'b10; we_b = 2'b00; addr_b1 = 8'h04; wdata_b1 = 8'h5A;
        step();
        check_eq("lat3_gnt",   gnt_b,       2'b10);
        check_eq("lat3_en",    mem_en_b,    1'b1);
        check_eq("lat3_we",    mem_we_b,    1'b0);
        check_eq("lat3_addr",  mem_addr_b,  8'h04);
        check_eq("lat3_wdata", mem_wdata_b, 8'h5A);
        req_b = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq("lat3_early_rvalid", rvalid_b, 2'b00);
        end
        step();
        check_eq("lat3_rvalid", rvalid_b, 2'b10);
        check_eq("lat3_rdata",  rdata_b,  8'd42);

        reset = 1'b0; req = 2'b00;
        step();
        reset = 1'b1;
        req = 2'b11; we = 2'b11; lock = 2'b01;
        set_port(0, 8'h10, 8'h11); set_port(1, 8'h20, 8'h22);
        ngr = 0; n1 = 0;
        for (int i = 0; i < 40 && ngr < 8; i++) begin
            step();
            if (gnt != 2'b00) begin
                seq[ngr] = gnt[1] ? 1 : 0;
                n1 += seq[ngr];
                set_port(seq[ngr], AW'($urandom_range(0, 15)), DW'($urandom));
                ngr++;
            end
        end
        check_eq("cont_grants", ngr, 8);
        for (int i = 0; i < ngr; i++) begin
`ifdef DMEM_ARB_LOCK_EN
            check_eq("cont_seq", seq[i], (i == 4) ? 1 : 0);
`else
            check_eq("cont_seq", seq[i], i % 2);
`endif
        end
`ifdef DMEM_ARB_LOCK_EN
        check_eq("cont_port1_count", n1, 1);
`else
        check_eq("cont_port1_count", n1, 4);
`endif
        req = 2'b00; lock = 2'b00;
        repeat (3) step();

        repeat (600) rand_cycle();

        req = 2'b01; we = 2'b00; lock = 2'b00; addr0 = 8'h07;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            if (gnt[0] && mem_en && !mem_we) ok = 1'b1;
        end
        check_eq("midrst_read_issued", ok, 1'b1);
        req = 2'b00;
        step();
        reset = 1'b0;
        step();
        check_eq("midrst_rvalid", rvalid, 2'b00);
        check_eq("midrst_mem_en", mem_en, 1'b0);
        check_eq("midrst_gnt",    gnt,    2'b00);
        reset = 1'b1;
        t0 = cyc;
        req = 2'b10; we = 2'b00; addr1 = 8'h03;
        step();
        check_eq("post_rst_gnt", gnt, 2'b10);
        check_eq("post_rst_cycle", cyc - t0, 1);
        req = 2'b00;
        repeat (3) step();

        repeat (600) rand_cycle();
        req = 2'b00;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
